alarm_clock_ctrl: RTL and testbench
===================================

Name: alarm_clock_ctrl

Overview:
Central controller for the alarm clock. It consumes the 1 Hz time base and debounced push-button pulses, and keeps the HH:MM:SS time-of-day and the alarm time. It runs the user set-mode state machine and the alarm ring/snooze sequencer. Its outputs drive the display/BCD stage and the buzzer.

Parameters:
RING_TIMEOUT_S, 60, seconds a ring lasts before auto-stopping (1..255)
SNOOZE_MIN, 5, snooze length in minutes (1..59); used only with SNOOZE_EN
ALARM_RST_HR, 7, alarm hour loaded at reset (0..23)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick_1hz  in  1  one-clk-wide enable strobe, once per second
btn_mode  in  1  one-clk pulse (debounced): advance set mode
btn_inc  in  1  one-clk pulse: increment selected field / snooze
btn_off  in  1  one-clk pulse: silence alarm
alarm_en  in  1  level switch: alarm armed
hours  out  5  current hour 0..23
minutes  out  6  current minute 0..59
seconds  out  6  current second 0..59
al_hours  out  5  alarm hour
al_minutes  out  6  alarm minute
mode  out  3  current set mode (encoding below)
blink  out  1  display blink phase for the field being edited
ring  out  1  buzzer enable

Behaviour:
- Single clock domain: clk. rst is synchronous, active-high.
- Reset values: time 00:00:00; alarm ALARM_RST_HR:00; mode=RUN; blink=0; ring=0; ring FSM=IDLE; all internal counters 0.
- Mode FSM, encoding: RUN=0, SET_HR=1, SET_MIN=2, SET_AL_HR=3, SET_AL_MIN=4. btn_mode advances RUN→SET_HR→SET_MIN→SET_AL_HR→SET_AL_MIN→RUN. Registered outputs: mode changes the cycle after the pulse.
- Timekeeping: on tick_1hz in RUN, SET_AL_HR or SET_AL_MIN, seconds increment. 59→0 carries to minutes. Minute 59→0 carries to hours. Hour 23→0 wraps.
- In SET_HR and SET_MIN, ticks are ignored and time is frozen.
- On the SET_MIN→SET_AL_HR transition, seconds are cleared to 0.
- btn_inc in a set mode increments only the selected field, with wrap and no carry: hours 23→0, minutes 59→0.
- btn_inc in RUN has no effect on time (snooze only; see Optional Feature).
- Simultaneous events:
  - btn_mode with btn_inc: mode change wins; the inc is dropped.
  - tick with btn_inc in an alarm-set mode: both apply in the same cycle.
- blink: toggles on every tick while mode≠RUN. It is forced to 0 in RUN and on any mode change.
- Ring FSM: IDLE, RINGING (plus SNOOZED when SNOOZE_EN is defined).
  - IDLE→RINGING when all of these hold: alarm_en=1, mode is RUN or an alarm-set mode, a tick rolls time to hh:mm:00, and hh:mm equals al_hours:al_minutes. ring goes 1 the cycle after that tick.
  - RINGING→IDLE on btn_off, on alarm_en=0, or after RING_TIMEOUT_S ticks, whichever comes first. The 8-bit ring counter clears on entry.
  - Editing the alarm fields while RINGING does not stop the ring.
  - A match cannot re-trigger within the same minute.
- Reset mid-ring: ring drops to 0 the cycle after rst.

Optional Feature:
SNOOZE_EN.
- Defined: btn_inc in RUN while RINGING moves the ring FSM to SNOOZED. ring=0 in SNOOZED; a 12-bit counter counts SNOOZE_MIN*60 ticks, then returns to RINGING with the timeout counter cleared. btn_off or alarm_en=0 in SNOOZED returns to IDLE. btn_inc in SNOOZED is ignored.
- Not defined: no SNOOZED state and no snooze counter; btn_inc in RUN is ignored entirely.

Decomposition:
- Package alarm_clock_pkg holds:
  - mode enum (3-bit) and ring-state enum;
  - constants MAX_HR=23, MAX_MIN=59, MAX_SEC=59;
  - widths HR_W=5, MIN_W=6.
- One natural sub-module, hms_counter: the time-of-day register with tick enable, per-field increment inputs and wrap/carry logic. It is instantiated once for the time-of-day. Alarm hh:mm stays in the controller because it needs no carry.

Test Plan:
- Reset, then 3661 ticks in RUN → time 01:01:01; ring=0; blink=0.
- Preload 23:59:59 via set modes, one tick in RUN → 00:00:00.
- Set alarm 07:01, alarm_en=1, time 07:00:59, tick → ring=1 the next cycle. 60 further ticks → ring=0. btn_off in a second run stops the ring in 1 cycle.
- In SET_MIN: pulse btn_inc 61 times → minutes advance by 1 mod 60 (wrap), hours unchanged. 10 ticks → seconds unchanged. Advance to SET_AL_HR → seconds=0.
- btn_mode and btn_inc in the same cycle in SET_HR → mode=SET_MIN, hours unchanged.
- SNOOZE_EN, SNOOZE_MIN=1: while ringing, btn_inc → ring=0; after 60 ticks → ring=1 again. Without SNOOZE_EN the same stimulus leaves ring=1.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// -----------------------------------------------------------------------------
// alarm_clock_pkg
// Shared types and constants for the alarm clock controller.
//   mode_e : user set-mode encoding (3 bits, visible on the mode_o port)
//   ring_e : ring/snooze sequencer states
// Optional feature macro: SNOOZE_EN adds the RING_SNOOZED state.
// -----------------------------------------------------------------------------
package alarm_clock_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;

    localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;
    localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
    localparam logic [MIN_W-1:0] MAX_SEC = 6'd59;

    typedef enum logic [2:0] {
        MODE_RUN        = 3'd0,
        MODE_SET_HR     = 3'd1,
        MODE_SET_MIN    = 3'd2,
        MODE_SET_AL_HR  = 3'd3,
        MODE_SET_AL_MIN = 3'd4
    } mode_e;

`ifdef SNOOZE_EN
    typedef enum logic [1:0] {
        RING_IDLE    = 2'd0,
        RING_RINGING = 2'd1,
        RING_SNOOZED = 2'd2
    } ring_e;
`else
    typedef enum logic {
        RING_IDLE    = 1'b0,
        RING_RINGING = 1'b1
    } ring_e;
`endif

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:       return MODE_SET_HR;
            MODE_SET_HR:    return MODE_SET_MIN;
            MODE_SET_MIN:   return MODE_SET_AL_HR;
            MODE_SET_AL_HR: return MODE_SET_AL_MIN;
            default:        return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/alarm_clock_ctrl_hms_counter.sv
// -----------------------------------------------------------------------------
// hms_counter
// HH:MM:SS time-of-day register.
//   clk_i, rst_i    : clock, synchronous active-high reset (time -> 00:00:00)
//   tick_i          : advance one second with full carry chain
//   inc_hr_i        : bump hours only, 23 -> 0, no carry
//   inc_min_i       : bump minutes only, 59 -> 0, no carry
//   clr_sec_i       : force seconds to 0
//   hours_o/minutes_o/seconds_o : registered time
//   hours_nxt_o/minutes_nxt_o   : value hh:mm takes at the next edge
//   min_roll_o      : this tick wraps seconds to :00
// -----------------------------------------------------------------------------
module hms_counter
    import alarm_clock_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             inc_hr_i,
    input  logic             inc_min_i,
    input  logic             clr_sec_i,
    output logic [HR_W-1:0]  hours_o,
    output logic [MIN_W-1:0] minutes_o,
    output logic [MIN_W-1:0] seconds_o,
    output logic [HR_W-1:0]  hours_nxt_o,
    output logic [MIN_W-1:0] minutes_nxt_o,
    output logic             min_roll_o
);

    logic [HR_W-1:0]  hr_q,  hr_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [MIN_W-1:0] sec_q, sec_d;

    always_comb begin
        hr_d  = hr_q;
        min_d = min_q;
        sec_d = sec_q;
        if (tick_i) begin
            if (sec_q == MAX_SEC) begin
                sec_d = '0;
                if (min_q == MAX_MIN) begin
                    min_d = '0;
                    hr_d  = (hr_q == MAX_HR) ? '0 : hr_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        // Field edits only happen while ticks are frozen, so they never race the carry.
        if (inc_hr_i)  hr_d  = (hr_q  == MAX_HR)  ? '0 : hr_q  + 5'd1;
        if (inc_min_i) min_d = (min_q == MAX_MIN) ? '0 : min_q + 6'd1;
        if (clr_sec_i) sec_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hr_q  <= '0;
            min_q <= '0;
            sec_q <= '0;
        end else begin
            hr_q  <= hr_d;
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

    assign hours_o       = hr_q;
    assign minutes_o     = min_q;
    assign seconds_o     = sec_q;
    assign hours_nxt_o   = hr_d;
    assign minutes_nxt_o = min_d;
    assign min_roll_o    = tick_i && (sec_q == MAX_SEC);

endmodule

// File: rtl/alarm_clock_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_clock_ctrl
// Alarm clock controller: time-of-day, alarm time, set-mode FSM, ring sequencer.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   tick_1hz_i            : one-cycle strobe per second
//   btn_mode_i/_inc_i/_off_i : debounced one-cycle button pulses
//   alarm_en_i            : alarm armed (level)
//   hours_o/minutes_o/seconds_o : time of day
//   al_hours_o/al_minutes_o     : alarm time
//   mode_o                : set mode (RUN=0 .. SET_AL_MIN=4)
//   blink_o               : blink phase of the field being edited
//   ring_o                : buzzer enable
// Optional feature macro: SNOOZE_EN (snooze via btn_inc while ringing in RUN).
//
// Mode FSM
//   state           | meaning
//   MODE_RUN        | clock running, buttons only silence/snooze
//   MODE_SET_HR     | time frozen, btn_inc bumps hours
//   MODE_SET_MIN    | time frozen, btn_inc bumps minutes
//   MODE_SET_AL_HR  | time running, btn_inc bumps alarm hours
//   MODE_SET_AL_MIN | time running, btn_inc bumps alarm minutes
// Ring FSM
//   state           | meaning
//   RING_IDLE       | buzzer off, waiting for an alarm match
//   RING_RINGING    | buzzer on, timeout counter running
//   RING_SNOOZED    | buzzer off, snooze counter running (SNOOZE_EN only)
// -----------------------------------------------------------------------------
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned RING_TIMEOUT_S = 60,
`ifdef SNOOZE_EN
    parameter int unsigned SNOOZE_MIN     = 5,
`endif
    parameter int unsigned ALARM_RST_HR   = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_1hz_i,
    input  logic             btn_mode_i,
    input  logic             btn_inc_i,
    input  logic             btn_off_i,
    input  logic             alarm_en_i,
    output logic [HR_W-1:0]  hours_o,
    output logic [MIN_W-1:0] minutes_o,
    output logic [MIN_W-1:0] seconds_o,
    output logic [HR_W-1:0]  al_hours_o,
    output logic [MIN_W-1:0] al_minutes_o,
    output logic [2:0]       mode_o,
    output logic             blink_o,
    output logic             ring_o
);

    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);
`ifdef SNOOZE_EN
    localparam logic [11:0] SNZ_LAST = 12'(SNOOZE_MIN * 60 - 1);
`endif

    mode_e            mode_q, mode_d;
    ring_e            ring_q, ring_d;
    logic             blink_q, blink_d;
    logic [HR_W-1:0]  al_hr_q, al_hr_d;
    logic [MIN_W-1:0] al_min_q, al_min_d;
    logic [7:0]       ring_cnt_q, ring_cnt_d;
`ifdef SNOOZE_EN
    logic [11:0]      snz_cnt_q, snz_cnt_d;
    logic             snooze_req;
`endif

    logic             inc_ok, tick_en, clr_sec;
    logic             inc_hr, inc_min, inc_al_hr, inc_al_min;
    logic [HR_W-1:0]  hours_nxt;
    logic [MIN_W-1:0] minutes_nxt;
    logic             min_roll, alarm_hit;

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) mode_q <= MODE_RUN;
        else       mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (btn_mode_i) mode_d = next_mode(mode_q);
    end

    // A mode press swallows a coincident inc.
    always_comb begin
        inc_ok     = btn_inc_i && !btn_mode_i;
        tick_en    = tick_1hz_i && (mode_q == MODE_RUN || mode_q == MODE_SET_AL_HR ||
                                    mode_q == MODE_SET_AL_MIN);
        clr_sec    = btn_mode_i && (mode_q == MODE_SET_MIN);
        inc_hr     = inc_ok && (mode_q == MODE_SET_HR);
        inc_min    = inc_ok && (mode_q == MODE_SET_MIN);
        inc_al_hr  = inc_ok && (mode_q == MODE_SET_AL_HR);
        inc_al_min = inc_ok && (mode_q == MODE_SET_AL_MIN);
        mode_o     = mode_q;
    end

    // ---------------- time, alarm, blink ----------------
    hms_counter u_tod (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tick_i        (tick_en),
        .inc_hr_i      (inc_hr),
        .inc_min_i     (inc_min),
        .clr_sec_i     (clr_sec),
        .hours_o       (hours_o),
        .minutes_o     (minutes_o),
        .seconds_o     (seconds_o),
        .hours_nxt_o   (hours_nxt),
        .minutes_nxt_o (minutes_nxt),
        .min_roll_o    (min_roll)
    );

    always_comb begin
        al_hr_d  = inc_al_hr  ? ((al_hr_q  == MAX_HR)  ? '0 : al_hr_q  + 5'd1) : al_hr_q;
        al_min_d = inc_al_min ? ((al_min_q == MAX_MIN) ? '0 : al_min_q + 6'd1) : al_min_q;
        if (btn_mode_i || mode_q == MODE_RUN) blink_d = 1'b0;
        else if (tick_1hz_i)                  blink_d = ~blink_q;
        else                                  blink_d = blink_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            al_hr_q  <= HR_W'(ALARM_RST_HR);
            al_min_q <= '0;
            blink_q  <= 1'b0;
        end else begin
            al_hr_q  <= al_hr_d;
            al_min_q <= al_min_d;
            blink_q  <= blink_d;
        end
    end

    assign al_hours_o   = al_hr_q;
    assign al_minutes_o = al_min_q;
    assign blink_o      = blink_q;

    // Match is taken against the alarm value before any same-cycle edit. Only the
    // tick that rolls to :00 can fire, so one minute can never trigger twice.
    assign alarm_hit = alarm_en_i && tick_en && min_roll &&
                       (hours_nxt == al_hr_q) && (minutes_nxt == al_min_q);

    // ---------------- ring FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ring_q     <= RING_IDLE;
            ring_cnt_q <= '0;
`ifdef SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else begin
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
`ifdef SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

`ifdef SNOOZE_EN
    assign snooze_req = inc_ok && (mode_q == MODE_RUN);
`endif

    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
`ifdef SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        case (ring_q)
            RING_IDLE: begin
                if (alarm_hit) begin
                    ring_d     = RING_RINGING;
                    ring_cnt_d = '0;
                end
            end
            RING_RINGING: begin
                if (btn_off_i || !alarm_en_i) begin
                    ring_d = RING_IDLE;
`ifdef SNOOZE_EN
                end else if (snooze_req) begin
                    ring_d    = RING_SNOOZED;
                    snz_cnt_d = '0;
`endif
                end else if (tick_1hz_i) begin
                    if (ring_cnt_q == RING_LAST) ring_d = RING_IDLE;
                    else                         ring_cnt_d = ring_cnt_q + 8'd1;
                end
            end
`ifdef SNOOZE_EN
            RING_SNOOZED: begin
                if (btn_off_i || !alarm_en_i) begin
                    ring_d = RING_IDLE;
                end else if (tick_1hz_i) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        ring_d     = RING_RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 12'd1;
                    end
                end
            end
`endif
            default: ring_d = RING_IDLE;
        endcase
    end

    always_comb begin
        ring_o = (ring_q == RING_RINGING);
    end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
module tb_alarm_clock_ctrl;

    localparam int RT     = 60;
    localparam int SNZ_M  = 1;
    localparam int AL_RST = 7;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       tick_i = 1'b0, bmode_i = 1'b0, binc_i = 1'b0, boff_i = 1'b0, en_i = 1'b0;
    logic [4:0] hours, al_hours;
    logic [5:0] minutes, seconds, al_minutes;
    logic [2:0] mode;
    logic       blink, ring;

    int checks = 0;
    int failures = 0;

    // reference model: time kept as seconds-of-day, ring counters as ticks remaining
    int m_tod, m_alh, m_alm, m_mode, m_ring, m_ring_left, m_snz_left;
    bit m_blink;

    always #5 clk = ~clk;

    alarm_clock_ctrl #(
        .RING_TIMEOUT_S(RT),
`ifdef SNOOZE_EN
        .SNOOZE_MIN(SNZ_M),
`endif
        .ALARM_RST_HR(AL_RST)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .tick_1hz_i(tick_i), .btn_mode_i(bmode_i),
        .btn_inc_i(binc_i), .btn_off_i(boff_i), .alarm_en_i(en_i),
        .hours_o(hours), .minutes_o(minutes), .seconds_o(seconds),
        .al_hours_o(al_hours), .al_minutes_o(al_minutes), .mode_o(mode),
        .blink_o(blink), .ring_o(ring)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_alh = AL_RST; m_alm = 0; m_mode = 0; m_blink = 0;
        m_ring = 0; m_ring_left = 0; m_snz_left = 0;
    endtask

    task automatic model_step(input bit t, input bit bm, input bit bi, input bit bo, input bit en);
        int  tod, h, mi, s, old_tod;
        bit  tick_en, inc_ok, hit, snooze;
        inc_ok  = bi && !bm;
        tick_en = t && (m_mode == 0 || m_mode >= 3);
        old_tod = m_tod;
        tod = tick_en ? (m_tod + 1) % 86400 : m_tod;
        h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
        if (inc_ok && m_mode == 1) h = (h + 1) % 24;
        if (inc_ok && m_mode == 2) mi = (mi + 1) % 60;
        if (bm && m_mode == 2) s = 0;
        tod = h * 3600 + mi * 60 + s;
        hit = en && tick_en && (old_tod % 60 == 59) && (tod / 60 == m_alh * 60 + m_alm);
`ifdef SNOOZE_EN
        snooze = inc_ok && m_mode == 0;
`else
        snooze = 0;
`endif
        case (m_ring)
            0: if (hit) begin m_ring = 1; m_ring_left = RT; end
            1: begin
                if (bo || !en) m_ring = 0;
                else if (snooze) begin m_ring = 2; m_snz_left = SNZ_M * 60; end
                else if (t) begin
                    m_ring_left--;
                    if (m_ring_left == 0) m_ring = 0;
                end
            end
            default: begin
                if (bo || !en) m_ring = 0;
                else if (t) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin m_ring = 1; m_ring_left = RT; end
                end
            end
        endcase
        if (inc_ok && m_mode == 3) m_alh = (m_alh + 1) % 24;
        if (inc_ok && m_mode == 4) m_alm = (m_alm + 1) % 60;
        if (bm || m_mode == 0) m_blink = 0;
        else if (t) m_blink = ~m_blink;
        if (bm) m_mode = (m_mode + 1) % 5;
        m_tod = tod;
    endtask

    task automatic check_all();
        chk("hours", int'(hours), m_tod / 3600);
        chk("minutes", int'(minutes), (m_tod / 60) % 60);
        chk("seconds", int'(seconds), m_tod % 60);
        chk("al_hours", int'(al_hours), m_alh);
        chk("al_minutes", int'(al_minutes), m_alm);
        chk("mode", int'(mode), m_mode);
        chk("blink", int'(blink), int'(m_blink));
        chk("ring", int'(ring), int'(m_ring == 1));
    endtask

    task automatic cyc(input bit t, input bit bm, input bit bi, input bit bo);
        tick_i = t; bmode_i = bm; binc_i = bi; boff_i = bo;
        @(posedge clk);
        model_step(t, bm, bi, bo, en_i);
        #1;
        check_all();
        tick_i = 0; bmode_i = 0; binc_i = 0; boff_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        @(posedge clk);
        model_reset();
        #1;
        check_all();
        rst_i = 0;
    endtask

    // Walk the set modes to load time h:m:s and alarm ah:am, ending in RUN.
    task automatic configure(input int h, input int m, input int s, input int ah, input int am);
        for (int i = 0; i < 5 && m_mode != 1; i++) cyc(0, 1, 0, 0);
        repeat ((h - m_tod / 3600 + 24) % 24) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        repeat ((m - (m_tod / 60) % 60 + 60) % 60) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        repeat (s) cyc(1, 0, 0, 0);
        repeat ((ah - m_alh + 24) % 24) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        repeat ((am - m_alm + 60) % 60) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
    endtask

    initial begin
        int h0, m0, s0;
        model_reset();
        do_reset();
        do_reset();
        chk("reset_hours", int'(hours), 0);
        chk("reset_al_hours", int'(al_hours), AL_RST);
        chk("reset_mode", int'(mode), 0);

        // 3661 ticks in RUN
        repeat (3661) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        chk("run_hours", int'(hours), 1);
        chk("run_minutes", int'(minutes), 1);
        chk("run_seconds", int'(seconds), 1);
        chk("run_ring", int'(ring), 0);
        chk("run_blink", int'(blink), 0);

        // 23:59:59 rolls to midnight
        configure(23, 59, 59, AL_RST, 0);
        chk("pre_wrap_sec", int'(seconds), 59);
        cyc(1, 0, 0, 0);
        chk("wrap_hours", int'(hours), 0);
        chk("wrap_minutes", int'(minutes), 0);
        chk("wrap_seconds", int'(seconds), 0);

        // alarm 07:01 fires on the roll from 07:00:59, times out after 60 ticks
        en_i = 1;
        configure(7, 0, 59, 7, 1);
        chk("ring_before", int'(ring), 0);
        cyc(1, 0, 0, 0);
        chk("ring_on", int'(ring), 1);
        repeat (RT - 1) cyc(1, 0, 0, 0);
        chk("ring_still_on", int'(ring), 1);
        cyc(1, 0, 0, 0);
        chk("ring_timeout", int'(ring), 0);

        // second run, silenced by btn_off
        configure(7, 0, 59, 7, 1);
        cyc(1, 0, 0, 0);
        chk("ring_on2", int'(ring), 1);
        cyc(0, 0, 0, 1);
        chk("ring_off_btn", int'(ring), 0);

        // reset in the middle of a ring
        configure(7, 0, 59, 7, 1);
        cyc(1, 0, 0, 0);
        chk("ring_on3", int'(ring), 1);
        do_reset();
        chk("ring_after_rst", int'(ring), 0);

        // SET_MIN: 61 incs wrap, ticks frozen, seconds cleared leaving SET_MIN
        configure(5, 30, 17, AL_RST, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("in_set_min", int'(mode), 2);
        h0 = m_tod / 3600; m0 = (m_tod / 60) % 60; s0 = m_tod % 60;
        repeat (61) cyc(0, 0, 1, 0);
        chk("setmin_minutes", int'(minutes), (m0 + 1) % 60);
        chk("setmin_hours", int'(hours), h0);
        repeat (10) cyc(1, 0, 0, 0);
        chk("setmin_frozen_sec", int'(seconds), s0);
        cyc(0, 1, 0, 0);
        chk("al_hr_mode", int'(mode), 3);
        chk("sec_cleared", int'(seconds), 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);

        // mode press beats inc in SET_HR
        cyc(0, 1, 0, 0);
        h0 = m_tod / 3600;
        cyc(0, 1, 1, 0);
        chk("mode_wins", int'(mode), 2);
        chk("inc_dropped", int'(hours), h0);
        repeat (4) cyc(0, 1, 0, 0);

        // snooze: btn_inc in RUN while ringing
        configure(7, 0, 59, 7, 1);
        cyc(1, 0, 0, 0);
        chk("snz_ring_on", int'(ring), 1);
        cyc(0, 0, 1, 0);
`ifdef SNOOZE_EN
        chk("snz_ring_off", int'(ring), 0);
`else
        chk("no_snz_ring", int'(ring), 1);
`endif
        repeat (SNZ_M * 60) cyc(1, 0, 0, 0);
`ifdef SNOOZE_EN
        chk("snz_ring_back", int'(ring), 1);
`endif
        cyc(0, 0, 0, 1);

        // randomized traffic near an armed alarm
        configure(6, 59, 0, 7, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) en_i = ~en_i;
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
